// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds each instruction for CPI clocks,
// then retires it, with stall, redirect, halt and retire-limit control.
module pc_sequencer #(
  parameter int PC_W = 32,
  parameter int CPI = 30,
  parameter int PC_STEP = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int MAX_INSTR = 109,
  parameter int CNT_W = 16,
  localparam int CYC_W = (CPI > 1) ? $clog2(CPI) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_pc,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            instr_start,
  output logic [CYC_W-1:0] cycle_idx,
  output logic [CNT_W-1:0] retired_cnt,
  output logic            busy,
  output logic            done
);

  localparam logic [CYC_W-1:0] LAST = CYC_W'(CPI - 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_INSTR);
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_pend_pc;
  logic             r_pend;
  logic [CYC_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_istart;

  logic             w_run;
  logic             w_begin;
  logic             w_halt;
  logic             w_stall;
  logic             w_step;
  logic             w_retire;
  logic             w_at_last;
  logic             w_limit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PC_W-1:0]  w_pc_nxt;

  assign w_run     = (r_state == S_RUN);
  assign w_at_last = (r_cyc == LAST);
  assign w_begin   = !w_run && start;
  assign w_halt    = w_run && halt;
  assign w_stall   = w_run && !halt && stall;
  assign w_step    = w_run && !halt && !stall && !w_at_last;
  assign w_retire  = w_run && !halt && !stall && w_at_last;

  // Unlimited runs pin the counter at all-ones instead of wrapping.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_nxt = ((MAX_INSTR == 0) && (&r_cnt)) ? r_cnt : w_cnt_inc;
  assign w_limit   = (MAX_INSTR != 0) && (w_cnt_inc == MAXC);

  assign w_pc_nxt = load_en ? load_pc :
                    r_pend  ? r_pend_pc :
                              r_pc + STEP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_halt || (w_retire && w_limit))
          w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_pend    <= 1'b0;
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_istart  <= 1'b0;
    end else begin
      unique case (1'b1)
        w_begin: begin
          r_cyc    <= '0;
          r_cnt    <= '0;
          r_istart <= 1'b1;
          r_pend   <= 1'b0;
        end
        w_halt: begin
          r_istart <= 1'b0;
        end
        w_stall: begin
          if (load_en) begin
            r_pend    <= 1'b1;
            r_pend_pc <= load_pc;
          end
        end
        w_step: begin
          r_cyc    <= r_cyc + 1'b1;
          r_istart <= 1'b0;
          if (load_en) begin
            r_pend    <= 1'b1;
            r_pend_pc <= load_pc;
          end
        end
        w_retire: begin
          r_pc     <= w_pc_nxt;
          r_cnt    <= w_cnt_nxt;
          r_cyc    <= '0;
          r_istart <= !w_limit;
          r_pend   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    pc          = r_pc;
    instr_start = r_istart;
    cycle_idx   = r_cyc;
    retired_cnt = r_cnt;
    busy        = (r_state == S_RUN);
    done        = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (default, CPI=4, CPI=1 wrap)
// driven by vector rows whose expectations are checked via a queue.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs[3], st[3], sl[3], ld[3], hl[3];
  logic [31:0] lpc[3];
  logic [31:0] pc[3];
  logic        ist[3], bz[3], dn[3];
  logic [15:0] rc[3];
  logic [4:0]  cy[3];
  logic [4:0]  cy0;
  logic [1:0]  cy1;
  logic [0:0]  cy2;

  assign cy[0] = cy0;
  assign cy[1] = {3'b0, cy1};
  assign cy[2] = {4'b0, cy2};

  pc_sequencer u0 (
    .clk(clk), .rst_n(rs[0]), .start(st[0]), .stall(sl[0]),
    .load_en(ld[0]), .load_pc(lpc[0]), .halt(hl[0]),
    .pc(pc[0]), .instr_start(ist[0]), .cycle_idx(cy0),
    .retired_cnt(rc[0]), .busy(bz[0]), .done(dn[0])
  );

  pc_sequencer #(.CPI(4), .MAX_INSTR(0)) u1 (
    .clk(clk), .rst_n(rs[1]), .start(st[1]), .stall(sl[1]),
    .load_en(ld[1]), .load_pc(lpc[1]), .halt(hl[1]),
    .pc(pc[1]), .instr_start(ist[1]), .cycle_idx(cy1),
    .retired_cnt(rc[1]), .busy(bz[1]), .done(dn[1])
  );

  pc_sequencer #(
    .CPI(1), .RESET_PC(32'hFFFF_FFFE), .MAX_INSTR(0)
  ) u2 (
    .clk(clk), .rst_n(rs[2]), .start(st[2]), .stall(sl[2]),
    .load_en(ld[2]), .load_pc(lpc[2]), .halt(hl[2]),
    .pc(pc[2]), .instr_start(ist[2]), .cycle_idx(cy2),
    .retired_cnt(rc[2]), .busy(bz[2]), .done(dn[2])
  );

  typedef struct {
    int          d;
    logic        rs, st, sl, ld, hl;
    logic [31:0] lpc;
    logic [31:0] pc;
    logic        ist;
    int          cy;
    int          rc;
    logic        bz, dn;
    bit          ccy;
    string       nm;
  } vec_t;

  function automatic vec_t mk(
    int d, logic rs_i, logic st_i, logic sl_i, logic ld_i,
    logic hl_i, logic [31:0] lpc_i, logic [31:0] pc_e,
    logic ist_e, int cy_e, int rc_e, logic bz_e, logic dn_e,
    bit ccy_e, string nm
  );
    vec_t v;
    v.d = d; v.rs = rs_i; v.st = st_i; v.sl = sl_i;
    v.ld = ld_i; v.hl = hl_i; v.lpc = lpc_i;
    v.pc = pc_e; v.ist = ist_e; v.cy = cy_e; v.rc = rc_e;
    v.bz = bz_e; v.dn = dn_e; v.ccy = ccy_e; v.nm = nm;
    return v;
  endfunction

  vec_t q[$];
  vec_t tbl[$];
  vec_t mv;
  int checks = 0;
  int errors = 0;

  logic [31:0] e_pc;
  int          e_cy, e_rc;
  logic        e_is;

  task automatic chk(string nm, string f,
                     logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, f, a, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mv = q.pop_front();
      chk(mv.nm, "pc", pc[mv.d], mv.pc);
      chk(mv.nm, "instr_start", 32'(ist[mv.d]), 32'(mv.ist));
      if (mv.ccy)
        chk(mv.nm, "cycle_idx", 32'(cy[mv.d]), mv.cy);
      chk(mv.nm, "retired_cnt", 32'(rc[mv.d]), mv.rc);
      chk(mv.nm, "busy", 32'(bz[mv.d]), 32'(mv.bz));
      chk(mv.nm, "done", 32'(dn[mv.d]), 32'(mv.dn));
    end
  end

  task automatic apply(vec_t v);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1; st[i] = 1'b0; sl[i] = 1'b0;
      ld[i] = 1'b0; hl[i] = 1'b0; lpc[i] = '0;
    end
    rs[v.d] = v.rs; st[v.d] = v.st; sl[v.d] = v.sl;
    ld[v.d] = v.ld; hl[v.d] = v.hl; lpc[v.d] = v.lpc;
    q.push_back(v);
  endtask

  // Plain sequencing model: no stall, load, halt or limit.
  task automatic tick(int d, int cpi, string nm);
    e_cy++;
    if (e_cy == cpi) begin
      e_cy = 0; e_pc++; e_rc++; e_is = 1'b1;
    end else begin
      e_is = 1'b0;
    end
    apply(mk(d, 1, 0, 0, 0, 0, 0, e_pc, e_is,
             e_cy, e_rc, 1, 0, 1, nm));
  endtask

  task automatic zero_model();
    e_pc = 0; e_cy = 0; e_rc = 0; e_is = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b0; st[i] = 1'b0; sl[i] = 1'b0;
      ld[i] = 1'b0; hl[i] = 1'b0; lpc[i] = '0;
    end
    repeat (2) @(negedge clk);

    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,1,"rst0"));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,1,"rst1"));
    tbl.push_back(mk(2,0,0,0,0,0,0,
      32'hFFFF_FFFE,0,0,0,0,0,1,"rst2"));
    tbl.push_back(mk(1,1,1,0,0,0,0, 0,1,0,0,1,0,1,"t2_start"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,1,0,1,0,1,"t2_c1"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,2,0,1,0,1,"t2_c2"));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,2,0,1,0,1,"t2_st1"));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,2,0,1,0,1,"t2_st2"));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,2,0,1,0,1,"t2_st3"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,3,0,1,0,1,"t2_c3"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1,1,0,1,1,0,1,"t2_ret"));
    tbl.push_back(mk(1,1,1,0,0,0,0, 1,0,1,1,1,0,1,"t2_st_ign"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1,0,2,1,1,0,1,"t2_n2"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1,0,3,1,1,0,1,"t2_n3"));
    tbl.push_back(mk(1,1,0,0,0,0,0, 2,1,0,2,1,0,1,"t2_ret2"));
    tbl.push_back(mk(2,1,0,1,1,0,32'h5,
      32'hFFFF_FFFE,0,0,0,0,0,1,"t4_idle_ign"));
    tbl.push_back(mk(2,1,1,0,0,0,0,
      32'hFFFF_FFFE,1,0,0,1,0,1,"t4_start"));
    tbl.push_back(mk(2,1,0,0,0,0,0,
      32'hFFFF_FFFF,1,0,1,1,0,1,"t4_ff"));
    tbl.push_back(mk(2,1,0,0,0,0,0, 0,1,0,2,1,0,1,"t4_wrap"));
    tbl.push_back(mk(2,1,0,1,0,0,0, 0,1,0,2,1,0,1,"t4_stall"));
    tbl.push_back(mk(2,1,0,0,0,0,0, 1,1,0,3,1,0,1,"t4_one"));
    foreach (tbl[i]) apply(tbl[i]);

    // Full default run to the retire limit.
    apply(mk(0,1,1,0,0,0,0, 0,1,0,0,1,0,1,"t1_start"));
    zero_model();
    for (int t = 1; t < 3270; t++) tick(0, 30, "t1_run");
    apply(mk(0,1,0,0,0,0,0, 109,0,0,109,0,1,1,"t1_done"));
    apply(mk(0,1,0,1,1,0,32'h7,
      109,0,0,109,0,1,1,"t1_hold"));

    // Halt mid-instruction, then restart keeping pc.
    apply(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,1,"t5_rst"));
    apply(mk(0,1,1,0,0,0,0, 0,1,0,0,1,0,1,"t5_start"));
    zero_model();
    for (int t = 0; t < 100; t++) tick(0, 30, "t5_run");
    apply(mk(0,1,0,0,0,1,0, 3,0,0,3,0,1,0,"t5_halt"));
    apply(mk(0,1,1,0,0,0,0, 3,1,0,0,1,0,1,"t5_restart"));
    e_pc = 3; e_cy = 0; e_rc = 0;

    // Pending redirect, then retire-cycle redirect precedence.
    for (int t = 0; t < 5; t++) tick(0, 30, "t3_a");
    apply(mk(0,1,0,0,1,0,32'h40, 3,0,6,0,1,0,1,"t3_ld40"));
    e_cy = 6;
    for (int t = 0; t < 23; t++) tick(0, 30, "t3_b");
    apply(mk(0,1,0,0,0,0,0, 32'h40,1,0,1,1,0,1,"t3_pc40"));
    e_pc = 32'h40; e_cy = 0; e_rc = 1;
    for (int t = 0; t < 5; t++) tick(0, 30, "t3_c");
    apply(mk(0,1,0,0,1,0,32'h44, 32'h40,0,6,1,1,0,1,"t3_ld44"));
    e_cy = 6;
    for (int t = 0; t < 23; t++) tick(0, 30, "t3_d");
    apply(mk(0,1,0,0,1,0,32'h80, 32'h80,1,0,2,1,0,1,"t3_pc80"));
    e_pc = 32'h80; e_cy = 0; e_rc = 2;

    // Reset with a load pending discards it.
    for (int t = 0; t < 3; t++) tick(0, 30, "t6_a");
    apply(mk(0,1,0,0,1,0,32'h99, 32'h80,0,4,2,1,0,1,"t6_ld99"));
    e_cy = 4;
    for (int t = 0; t < 3; t++) tick(0, 30, "t6_b");
    apply(mk(0,0,0,0,1,0,32'h55, 0,0,0,0,0,0,1,"t6_rst"));
    apply(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,1,"t6_idle"));
    apply(mk(0,1,1,0,0,0,0, 0,1,0,0,1,0,1,"t6_start"));
    zero_model();
    for (int t = 0; t < 30; t++) tick(0, 30, "t6_run");

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
